// File: rtl/i2s_tx_master_if.sv
// Sample stream into the I2S transmitter: stereo pair plus valid/ready handshake.
// The producer (master) drives the samples; the transmitter (slave) returns ready.
interface i2s_tx_master_if;
  logic signed [15:0] sample_l;
  logic signed [15:0] sample_r;
  logic               sample_valid;
  logic               sample_ready;

  modport master (output sample_l, output sample_r, output sample_valid, input sample_ready);
  modport slave  (input sample_l, input sample_r, input sample_valid, output sample_ready);
endinterface

// File: rtl/i2s_tx_master.sv
// I2S master transmitter: derives BCLK from CLK_AUDIO and serialises 16-bit stereo frames MSB first.
// A single holding register decouples the producer; the last frame repeats when no new sample arrives.
module i2s_tx_master #(
  parameter int CLK_DIV = 8
) (
  input  logic           CLK_AUDIO,
  input  logic           reset,
  input  logic           enable,
  i2s_tx_master_if.slave smp,
  output logic           i2s_bclk,
  output logic           i2s_ws,
  output logic           i2s_data,
  output logic           frame_start,
  output logic           underrun
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]   div;
  logic [4:0]         n;
  logic               hold_full;
  logic signed [15:0] hold_l;
  logic signed [15:0] hold_r;
  logic signed [15:0] cur_l;
  logic signed [15:0] cur_r;
  logic               tick;
  logic               fall;
  logic               latch;
  logic               xfer;

  // Bit driven at falling edge idx belongs to position idx-1, so ws leads data by one BCLK.
  function automatic logic pick_bit(input logic [4:0] idx,
                                    input logic signed [15:0] l,
                                    input logic signed [15:0] r);
    logic [4:0] p;
    logic [3:0] b;
    p = idx - 5'd1;
    b = 4'd15 - p[3:0];
    return p[4] ? r[b] : l[b];
  endfunction

  assign smp.sample_ready = ~hold_full & ~reset;
  assign xfer  = smp.sample_valid & smp.sample_ready;
  assign tick  = enable && (div == DIV_LAST);
  assign fall  = tick && i2s_bclk;
  assign latch = fall && (n == 5'd0);

  // Divider, serialiser and frame/holding control
  always_ff @(posedge CLK_AUDIO) begin
    if (reset) begin
      div         <= '0;
      n           <= 5'd0;
      i2s_bclk    <= 1'b0;
      i2s_ws      <= 1'b0;
      i2s_data    <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      hold_full   <= 1'b0;
      cur_l       <= '0;
      cur_r       <= '0;
    end else begin
      if (!enable) begin
        div         <= '0;
        n           <= 5'd0;
        i2s_bclk    <= 1'b0;
        i2s_ws      <= 1'b0;
        i2s_data    <= 1'b0;
        frame_start <= 1'b0;
        underrun    <= 1'b0;
      end else begin
        div <= tick ? '0 : div + DIV_W'(1);
        if (tick) i2s_bclk <= ~i2s_bclk;
        if (fall) begin
          i2s_ws   <= n[4];
          i2s_data <= pick_bit(n, cur_l, cur_r);
          n        <= n + 5'd1;
        end
        frame_start <= latch;
        underrun    <= latch & ~hold_full & ~xfer;
      end

      // The latch edge reads the old cur_r LSB above before cur is replaced here.
      if (latch) begin
        if (hold_full) begin
          cur_l     <= hold_l;
          cur_r     <= hold_r;
          hold_full <= 1'b0;
        end else if (xfer) begin
          cur_l <= smp.sample_l;
          cur_r <= smp.sample_r;
        end
      end else if (xfer) begin
        hold_full <= 1'b1;
      end
    end
  end

  // Holding data carries no reset; hold_full alone qualifies it
  always_ff @(posedge CLK_AUDIO) begin
    if (xfer && !latch) begin
      hold_l <= smp.sample_l;
      hold_r <= smp.sample_r;
    end
  end

endmodule

// File: tb/tb_i2s_tx_master.sv
// Bench for i2s_tx_master at CLK_DIV=2: directed frames, a word scoreboard fed by stimulus,
// and a monitor that rebuilds words from the serial line on BCLK rising edges.
module tb_i2s_tx_master;
  localparam int CLK_DIV = 2;
  localparam int FRAME   = 64 * CLK_DIV;

  logic CLK_AUDIO = 1'b0;
  logic reset;
  logic enable;
  logic bclk, ws, data, fs, ur;
  int   total = 0;
  int   bad   = 0;
  int   cyc_cnt = 0;
  logic [31:0] expq[$];

  i2s_tx_master_if bus();

  i2s_tx_master #(.CLK_DIV(CLK_DIV)) dut (
    .CLK_AUDIO  (CLK_AUDIO),
    .reset      (reset),
    .enable     (enable),
    .smp        (bus),
    .i2s_bclk   (bclk),
    .i2s_ws     (ws),
    .i2s_data   (data),
    .frame_start(fs),
    .underrun   (ur)
  );

  always #5 CLK_AUDIO = ~CLK_AUDIO;
  always @(posedge CLK_AUDIO) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wexp(input logic ch, input logic [15:0] w);
    return {15'd0, ch, w};
  endfunction

  task automatic push_frame(input logic [15:0] l, input logic [15:0] r);
    expq.push_back(wexp(1'b0, l));
    expq.push_back(wexp(1'b1, r));
  endtask

  // Returns #1 after the edge that registers frame_start; cyc = edges waited.
  task automatic wait_fs(output int cyc);
    cyc = 0;
    forever begin
      @(posedge CLK_AUDIO);
      #1;
      cyc++;
      if (fs) return;
      if (cyc > 4 * FRAME) begin
        check("frame_start_timeout", 32'(cyc), 32'(FRAME));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  endtask

  // Monitor: a word ends on the rise where ws differs from the previous rise.
  initial begin
    logic        prev_bclk;
    logic        prev_ws;
    logic [15:0] sr;
    logic [31:0] e;
    int          cnt;
    prev_bclk = 1'b0;
    prev_ws   = 1'b0;
    sr        = '0;
    cnt       = 0;
    forever begin
      @(negedge CLK_AUDIO);
      if (reset || !enable) begin
        cnt     = 0;
        prev_ws = 1'b0;
      end else if (bclk && !prev_bclk) begin
        sr = {sr[14:0], data};
        cnt++;
        if (ws != prev_ws) begin
          if (cnt >= 16) begin
            if (expq.size() == 0) begin
              check("word_unexpected", wexp(prev_ws, sr), 32'hFFFF_FFFF);
            end else begin
              e = expq.pop_front();
              check(prev_ws ? "word_right" : "word_left", wexp(prev_ws, sr), e);
            end
          end
          cnt = 0;
        end
        prev_ws = ws;
      end
      prev_bclk = bclk;
    end
  end

  initial begin
    int cyc;
    int t1;
    reset            = 1'b1;
    enable           = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_l     = '0;
    bus.sample_r     = '0;
    repeat (3) @(posedge CLK_AUDIO);
    #1;
    check("rst_bclk", {31'd0, bclk}, 32'd0);
    check("rst_ws", {31'd0, ws}, 32'd0);
    check("rst_data", {31'd0, data}, 32'd0);
    check("rst_frame_start", {31'd0, fs}, 32'd0);
    check("rst_underrun", {31'd0, ur}, 32'd0);
    check("rst_ready", {31'd0, bus.sample_ready}, 32'd0);

    // Release reset with S1 offered immediately
    reset = 1'b0;
    bus.sample_l = 16'hA5C3;
    bus.sample_r = 16'h3C5A;
    bus.sample_valid = 1'b1;
    #1;
    check("ready_after_rst", {31'd0, bus.sample_ready}, 32'd1);
    @(posedge CLK_AUDIO);
    #1;
    bus.sample_valid = 1'b0;
    wait_fs(cyc);
    check("first_fs_latency", 32'(cyc + 1), 32'(2 * CLK_DIV));
    check("f1_underrun", {31'd0, ur}, 32'd0);
    push_frame(16'hA5C3, 16'h3C5A);
    t1 = cyc_cnt;

    // No new sample: repeat and flag underrun
    wait_fs(cyc);
    check("frame_period", 32'(cyc_cnt - t1), 32'(FRAME));
    check("f2_underrun", {31'd0, ur}, 32'd1);
    push_frame(16'hA5C3, 16'h3C5A);

    // Back-to-back S2, S3
    bus.sample_l = 16'h1111;
    bus.sample_r = 16'h2222;
    bus.sample_valid = 1'b1;
    @(posedge CLK_AUDIO);
    #1;
    bus.sample_l = 16'h3333;
    bus.sample_r = 16'h4444;
    check("ready_low_hold_full", {31'd0, bus.sample_ready}, 32'd0);
    repeat (20) @(posedge CLK_AUDIO);
    #1;
    check("ready_still_low", {31'd0, bus.sample_ready}, 32'd0);
    wait_fs(cyc);
    check("f3_underrun", {31'd0, ur}, 32'd0);
    check("ready_after_latch", {31'd0, bus.sample_ready}, 32'd1);
    push_frame(16'h1111, 16'h2222);
    @(posedge CLK_AUDIO);
    #1;
    bus.sample_valid = 1'b0;
    wait_fs(cyc);
    check("f4_underrun", {31'd0, ur}, 32'd0);
    push_frame(16'h3333, 16'h4444);

    // Valid only in the latch cycle with hold empty: bypass into cur
    repeat (FRAME - 1) @(posedge CLK_AUDIO);
    #1;
    bus.sample_l = 16'h8001;
    bus.sample_r = 16'h7FFE;
    bus.sample_valid = 1'b1;
    wait_fs(cyc);
    bus.sample_valid = 1'b0;
    check("bypass_fs_edge", 32'(cyc), 32'd1);
    check("f5_underrun", {31'd0, ur}, 32'd0);
    check("bypass_hold_empty", {31'd0, bus.sample_ready}, 32'd1);
    push_frame(16'h8001, 16'h7FFE);
    wait_fs(cyc);
    check("f6_underrun", {31'd0, ur}, 32'd1);
    push_frame(16'h8001, 16'h7FFE);

    // Frame 7 abandoned at n=20 (right slot, bit 12 of 7FFE = 1)
    wait_fs(cyc);
    check("f7_underrun", {31'd0, ur}, 32'd1);
    expq.push_back(wexp(1'b0, 16'h8001));
    repeat (83) @(posedge CLK_AUDIO);
    #1;
    check("pre_drop_bclk", {31'd0, bclk}, 32'd1);
    check("pre_drop_ws", {31'd0, ws}, 32'd1);
    check("pre_drop_data", {31'd0, data}, 32'd1);
    enable = 1'b0;
    @(posedge CLK_AUDIO);
    #1;
    check("drop_bclk", {31'd0, bclk}, 32'd0);
    check("drop_ws", {31'd0, ws}, 32'd0);
    check("drop_data", {31'd0, data}, 32'd0);
    repeat (10) @(posedge CLK_AUDIO);
    #1;
    check("idle_frame_start", {31'd0, fs}, 32'd0);
    enable = 1'b1;
    wait_fs(cyc);
    check("restore_fs_latency", 32'(cyc), 32'(2 * CLK_DIV));
    check("f8_underrun", {31'd0, ur}, 32'd1);
    push_frame(16'h8001, 16'h7FFE);
    wait_fs(cyc);
    check("f9_underrun", {31'd0, ur}, 32'd1);
    repeat (8) @(posedge CLK_AUDIO);
    #1;
    check("words_left_unseen", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
